instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the MIPS core: holds the program counter, fetches instructions from instruction memory with a req/ack handshake, and presents the instruction register to the control unit and datapath. It sits directly upstream of the control decoder, which takes `instr[31:26]` as its opcode. It consumes the decoder's branch and jump outputs plus the ALU zero flag to compute the next PC. It also provides a retired-instruction counter and a fetch-timeout error flag.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word aligned.
- `TIMEOUT`, default 16: fetch cycles without `imem_ack` before a fetch error; valid range 1..255.
- `clk` in 1: clock. The block uses one clock; reset is synchronous and active-high.
- `rst` in 1: synchronous reset, active-high.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ack` in 1: instruction memory has `imem_rdata` valid this cycle.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: instruction register; `instr[31:26]` is the opcode for the control unit.
- `instr_valid` out 1: `instr` is being executed this cycle.
- `pc` out 32: address of the current instruction.
- `branch` in 1: from control; a conditional branch is decoded.
- `mux_branch_jump` in 1: from control; 0 selects jump.
- `alu_zero` in 1: ALU zero flag for the current instruction.
- `stall` in 1: holds the EXEC state, e.g. for a data-memory wait.
- `fetch_err` out 1: sticky flag; fetch timed out.
- `instr_count` out 32: number of retired instructions.

## Operation
- **States:**
  - FETCH: `imem_req`=1. On `imem_ack`, `instr` ← `imem_rdata` and go to EXEC. Otherwise increment `wait_cnt`; when `wait_cnt` reaches `TIMEOUT`, go to ERROR.
  - EXEC: `instr_valid`=1. If `stall`=1, hold. Otherwise `pc` ← `next_pc`, increment `instr_count`, clear `wait_cnt`, and go to FETCH.
  - ERROR: `imem_req`=0 and `instr_valid`=0. `fetch_err`=1. Leave ERROR only by reset.
- **Next PC:** `pc4` = `pc`+4, modulo 2^32.
  - Jump target: {`pc4[31:28]`, `instr[25:0]`, 2'b00}.
  - Branch target: `pc4` + (sign-extended `instr[15:0]` << 2), modulo 2^32.
  - `is_bne` = (`instr[31:26]` == 6'b000101).
  - Branch is taken when `branch` & (`alu_zero` ^ `is_bne`).
  - Priority: jump (`mux_branch_jump`=0), then taken branch, else `pc4`.
- **Ignored inputs:**
  - `imem_ack` outside FETCH.
  - `branch`, `alu_zero`, `mux_branch_jump` outside EXEC.
  - `stall` outside EXEC.
- **Reset values:**
  - `pc`/`imem_addr` = `RESET_PC`, `instr` = 0, `instr_count` = 0.
  - `imem_req` = 0, `instr_valid` = 0, `fetch_err` = 0, `wait_cnt` = 0.
  - State after reset: FETCH, entered on the first clock edge with `rst` low.
- **Reset mid-operation** (any state, including mid-fetch or ERROR): all outputs return to reset values on the next edge, and any pending ack is discarded.
- `instr_count` wraps from 2^32-1 to 0.
- `pc[1:0]` is always 0.

## Timing
- `imem_req` and `imem_addr` are registered. `imem_addr` is stable while `imem_req`=1.
- Handshake: `imem_rdata` is sampled on the edge where `imem_req`=1 and `imem_ack`=1.
  - Zero-wait memory (ack in the first FETCH cycle) gives 1 FETCH cycle.
  - Minimum throughput: 2 cycles per instruction.
- With N wait cycles (ack in FETCH cycle N+1): 1+N FETCH cycles, then 1 EXEC cycle, plus any `stall` cycles.
- Timeout: `wait_cnt` counts FETCH cycles without ack.
  - ERROR is entered on the edge ending the TIMEOUT-th ack-less cycle.
  - Ack in FETCH cycle TIMEOUT counts as a normal fetch; no error.
- `pc` and `instr_count` update on the edge ending the last EXEC cycle (the first with `stall`=0).
- `instr` and `pc` are constant for all EXEC cycles.
- The control unit is combinational from `instr`: decode, next PC and writeback all resolve within the EXEC cycle.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles.
  - During reset: `imem_req`=0, `imem_addr`=0, `instr_count`=0, `fetch_err`=0.
  - First cycle after release: `imem_req`=1, `imem_addr`=0x0.
- **Sequential fetch:** zero-wait memory returns ADDI words.
  - `imem_addr` sequence 0x0, 0x4, 0x8, each 2 cycles apart.
  - `instr_valid` pulses 1 cycle each.
  - `instr_count`=3 after the third EXEC.
- **Branches:** `pc`=0x10, instruction beq with offset 0xFFFE, `branch`=1.
  - `alu_zero`=1: next `imem_addr`=0x0C.
  - Same instruction with `alu_zero`=0: next `imem_addr`=0x14.
  - bne (opcode 000101) with `alu_zero`=1: next `imem_addr`=0x14.
- **Jump:** `pc`=0x1000_0000, `instr`=0x0800_0040, `mux_branch_jump`=0.
  - Next `imem_addr`=0x1000_0100.
- **Wait states and stall:**
  - Ack arrives 3 cycles late: `imem_addr` stays stable and `instr` updates only on the ack edge.
  - `stall`=1 for 2 EXEC cycles: `instr_valid` stays high 3 cycles, and `pc` and `instr_count` hold until `stall` drops.
- **Timeout:** with `TIMEOUT`=16, give no ack.
  - ERROR after 16 FETCH cycles: `fetch_err`=1, `imem_req`=0, held for more than 10 cycles.
  - Repeat with ack in FETCH cycle 16: no error.
  - Then assert `rst` mid-FETCH: `fetch_err`=0 and `pc`=`RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction memory port of the fetch stage: request/address out, ack/data back.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Fetch stage side: issues requests, receives instruction words.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Instruction memory side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, fetch handshake with timeout,
// instruction register, next-PC selection and retired-instruction counter.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_fetch_if.master        imem,
    output logic [31:0]                instr,
    output logic                       instr_valid,
    output logic [31:0]                pc,
    input  logic                       branch,
    input  logic                       mux_branch_jump,
    input  logic                       alu_zero,
    input  logic                       stall,
    output logic                       fetch_err,
    output logic [31:0]                instr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_ERROR
    } state_t;

    // wait_cnt equal to this value means the current ack-less cycle is the last allowed one.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t             state;
    logic [7:0]         wait_cnt;
    logic               req;

    logic [31:0]        pc4;
    logic [31:0]        jump_target;
    logic signed [31:0] branch_off;
    logic [31:0]        branch_target;
    logic               is_bne;
    logic               branch_taken;
    logic [31:0]        next_pc;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    // Next-PC selection: jump has priority over a taken branch, otherwise fall through.
    always_comb begin
        pc4           = pc + 32'd4;
        jump_target   = {pc4[31:28], instr[25:0], 2'b00};
        branch_off    = $signed({{14{instr[15]}}, instr[15:0], 2'b00});
        branch_target = pc4 + $unsigned(branch_off);
        is_bne        = (instr[31:26] == 6'b000101);
        branch_taken  = branch & (alu_zero ^ is_bne);
        next_pc       = pc4;
        if (!mux_branch_jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    // Fetch/execute state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_count <= '0;
            req         <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // First edge out of reset starts the first fetch.
                    state <= S_FETCH;
                    req   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        instr       <= imem.imem_rdata;
                        req         <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_EXEC;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        wait_cnt  <= wait_cnt + 8'd1;
                        req       <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    // Retire on the first non-stalled EXEC cycle.
                    if (!stall) begin
                        pc          <= next_pc;
                        instr_count <= instr_count + 32'd1;
                        wait_cnt    <= '0;
                        instr_valid <= 1'b0;
                        req         <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_ERROR: begin
                    // Sticky until reset.
                    req         <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes expected fetch
// addresses and executed instructions; a negedge monitor pops and compares.
module tb_instruction_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] cnt;
    } exec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        branch;
    logic        mux_branch_jump;
    logic        alu_zero;
    logic        stall;
    logic        fetch_err;
    logic [31:0] instr_count;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (bus),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .pc              (pc),
        .branch          (branch),
        .mux_branch_jump (mux_branch_jump),
        .alu_zero        (alu_zero),
        .stall           (stall),
        .fetch_err       (fetch_err),
        .instr_count     (instr_count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] addr_q[$];
    exec_t       exec_q[$];
    logic [31:0] cnt_exp    = 32'd0;
    logic [31:0] last_instr = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: new fetch requests and new EXEC entries are popped from the scoreboard.
    logic        req_prev   = 1'b0;
    logic        valid_prev = 1'b0;
    logic [31:0] addr_prev  = 32'd0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.imem_req === 1'b1 && req_prev !== 1'b1) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fetch_addr: actual fetch at %h, required no fetch", bus.imem_addr);
                end else begin
                    check("fetch_addr", bus.imem_addr, addr_q.pop_front());
                end
            end else if (bus.imem_req === 1'b1) begin
                check("addr_stable", bus.imem_addr, addr_prev);
            end
            if (instr_valid === 1'b1 && valid_prev !== 1'b1) begin
                if (exec_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL exec_entry: actual instr %h at pc %h, required none", instr, pc);
                end else begin
                    exec_t e;
                    e = exec_q.pop_front();
                    check("exec_pc", pc, e.pc);
                    check("exec_instr", instr, e.word);
                    check("exec_count", instr_count, e.cnt);
                end
            end
        end
        req_prev   = bus.imem_req;
        valid_prev = instr_valid;
        addr_prev  = bus.imem_addr;
    end

    // One instruction: optional wait states, ack, optional stall cycles, retire.
    task automatic run_instr(input logic [31:0] word, input int waits, input int stalls,
                             input logic br, input logic mbj, input logic zero,
                             input logic [31:0] exp_pc, input logic [31:0] exp_next);
        exec_t e;
        e.pc   = exp_pc;
        e.word = word;
        e.cnt  = cnt_exp;
        exec_q.push_back(e);
        for (int i = 0; i < waits; i++) begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 32'hBAD0_0000 | 32'(i);
            @(posedge clk); #1;
            check("wait_instr_hold", instr, last_instr);
            check("wait_req", 32'(bus.imem_req), 32'd1);
        end
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = word;
        branch          = br;
        mux_branch_jump = mbj;
        alu_zero        = zero;
        stall           = (stalls > 0);
        @(posedge clk); #1;
        last_instr = word;
        for (int i = 0; i < stalls; i++) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'hDEAD_BEEF;
            stall          = 1'b1;
            @(posedge clk); #1;
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc", pc, exp_pc);
            check("stall_count", instr_count, cnt_exp);
            check("stall_instr", instr, word);
        end
        stall        = 1'b0;
        bus.imem_ack = 1'b0;
        addr_q.push_back(exp_next);
        @(posedge clk); #1;
        cnt_exp = cnt_exp + 32'd1;
        check("retire_valid_low", 32'(instr_valid), 32'd0);
        check("retire_req", 32'(bus.imem_req), 32'd1);
        check("retire_count", instr_count, cnt_exp);
        check("retire_pc", pc, exp_next);
        branch          = 1'b0;
        mux_branch_jump = 1'b1;
        alu_zero        = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, "_addr"}, bus.imem_addr, 32'd0);
        check({tag, "_count"}, instr_count, 32'd0);
        check({tag, "_err"}, 32'(fetch_err), 32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, instr, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'd0;
        branch          = 1'b0;
        mux_branch_jump = 1'b1;
        alu_zero        = 1'b0;
        stall           = 1'b0;
        rst             = 1'b1;

        // Reset held for two cycles.
        @(posedge clk); #1;
        check_reset_state("rst1");
        @(posedge clk); #1;
        check_reset_state("rst2");
        addr_q.push_back(32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_req", 32'(bus.imem_req), 32'd1);
        check("post_reset_addr", bus.imem_addr, 32'h0);

        // Sequential zero-wait ADDI fetches.
        run_instr(32'h2001_0001, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0004);
        run_instr(32'h2002_0002, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0008);
        run_instr(32'h2003_0003, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_000C);
        check("count_after_three", instr_count, 32'd3);
        run_instr(32'h2004_0004, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_0010);

        // Branches around pc 0x10 with offset -2 words.
        run_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_000C);
        run_instr(32'h2004_0004, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_0010);
        run_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0014);
        run_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0014, 32'h0000_0010);
        run_instr(32'h1400_FFFE, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0014);
        run_instr(32'h1400_FFFE, 0, 0, 1'b1, 1'b1, 1'b0, 32'h0000_0014, 32'h0000_0010);

        // Jumps: into the 0x1000_0000 region, then the jump with pc4[31:28]=1.
        run_instr(32'h0800_0040, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0100);
        run_instr(32'h0BFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0FFF_FFFC);
        run_instr(32'h2005_0005, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0FFF_FFFC, 32'h1000_0000);
        run_instr(32'h0800_0040, 0, 0, 1'b1, 1'b0, 1'b1, 32'h1000_0000, 32'h1000_0100);

        // Three wait states plus two stall cycles.
        run_instr(32'h2006_0006, 3, 2, 1'b0, 1'b1, 1'b0, 32'h1000_0100, 32'h1000_0104);

        // Ack in the last allowed FETCH cycle is a normal fetch.
        run_instr(32'h2007_0007, 15, 0, 1'b0, 1'b1, 1'b0, 32'h1000_0104, 32'h1000_0108);
        check("late_ack_no_err", 32'(fetch_err), 32'd0);

        // No ack at all: timeout after 16 FETCH cycles.
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
        end
        check("pre_timeout_req", 32'(bus.imem_req), 32'd1);
        check("pre_timeout_err", 32'(fetch_err), 32'd0);
        @(posedge clk); #1;
        check("timeout_err", 32'(fetch_err), 32'd1);
        check("timeout_req", 32'(bus.imem_req), 32'd0);
        check("timeout_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 12; i++) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'hCAFE_0000;
            @(posedge clk); #1;
        end
        check("err_hold_err", 32'(fetch_err), 32'd1);
        check("err_hold_req", 32'(bus.imem_req), 32'd0);
        check("err_hold_valid", 32'(instr_valid), 32'd0);
        check("err_hold_count", instr_count, cnt_exp);
        bus.imem_ack = 1'b0;

        // Reset out of ERROR.
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_state("err_rst");
        check("err_rst_pc", pc, 32'h0);
        cnt_exp    = 32'd0;
        last_instr = 32'd0;
        addr_q.push_back(32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_instr(32'h2008_0008, 2, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0004);

        // Reset mid-FETCH with an ack pending on the same edge.
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst            = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBADC_0DE0;
        @(posedge clk); #1;
        check_reset_state("mid_rst");
        check("mid_rst_pc", pc, 32'h0);
        bus.imem_ack = 1'b0;
        cnt_exp      = 32'd0;
        last_instr   = 32'd0;
        addr_q.push_back(32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_instr(32'h2009_0009, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0004);

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("exec_q_drained", 32'(exec_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
